// File: rtl/raybox_vec_writer_if.sv
// Requester handshake bundle for raybox_vec_writer.
// req is a level held with data until the single-cycle ack.
interface raybox_vec_writer_if #(
   parameter int W = 16
);
   logic           req;
   logic [6*W-1:0] data;
   logic           ack;

   modport master (
      output req,
      output data,
      input  ack
   );

   modport slave (
      input  req,
      input  data,
      output ack
   );
endinterface

// File: rtl/raybox_vec_writer.sv
// Arbitrates two vector requesters and commits the staged set in vblank.
// RAYBOX_VEC_COALESCE_EN: the granted requester may replace staged data.
module raybox_vec_writer #(
   parameter int W        = 16,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525,
   parameter int SETTLE   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         py,
   raybox_vec_writer_if.slave a,
   raybox_vec_writer_if.slave b,
   output logic [6*W-1:0]     new_vectors,
   output logic               write_new_position,
   output logic               busy,
   output logic [7:0]         commit_count
);
   typedef enum logic [1:0] {
      IDLE,
      WAIT_VB,
      SETTLE_S,
      STROBE
   } state_t;

   state_t     state;
   logic       last_b;
   logic [3:0] cnt;
   logic       in_blank;
   logic       grant_a;
   logic       grant_b;

   // The final blank line is excluded so a commit never lands on line 0.
   assign in_blank = (py >= 10'(V_ACTIVE)) && (py <= 10'(V_TOTAL - 2));

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (a.req && (!b.req || last_b)) begin
                  grant_a = 1'b1;
               end else if (b.req) begin
                  grant_b = 1'b1;
               end
            end
`ifdef RAYBOX_VEC_COALESCE_EN
            WAIT_VB, SETTLE_S: begin
               grant_a = a.req && !last_b;
               grant_b = b.req && last_b;
            end
`endif
            default: begin
               grant_a = 1'b0;
               grant_b = 1'b0;
            end
         endcase
      end
   end

   assign a.ack = grant_a;
   assign b.ack = grant_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         last_b             <= 1'b1;
         cnt                <= '0;
         new_vectors        <= '0;
         write_new_position <= 1'b0;
         busy               <= 1'b0;
         commit_count       <= '0;
      end else begin
         write_new_position <= 1'b0;
         if (grant_a || grant_b) begin
            // A replace re-enters WAIT_VB so the settle window restarts.
            new_vectors <= grant_a ? a.data : b.data;
            last_b      <= grant_b;
            state       <= WAIT_VB;
            busy        <= 1'b1;
         end else begin
            case (state)
               WAIT_VB: begin
                  if (in_blank) begin
                     if (SETTLE == 1) begin
                        state              <= STROBE;
                        write_new_position <= 1'b1;
                     end else begin
                        state <= SETTLE_S;
                        cnt   <= 4'(SETTLE - 1);
                     end
                  end
               end
               SETTLE_S: begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     state              <= STROBE;
                     write_new_position <= 1'b1;
                  end
               end
               STROBE: begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  commit_count <= commit_count + 8'd1;
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end
endmodule
